regfile_sb: RTL

Parametrised integer register file with a built-in pending-write scoreboard, the next-generation replacement for the register array in the instruction decode stage. It provides NRD combinational read ports with optional write-to-read bypass and one synchronous write port. It also tracks which destination registers have an in-flight multi-cycle producer (load, ecall return), so the decode and hazard logic can stall on RAW hazards. Register 0 is hardwired to zero.

---
 rtl/regfile_sb.sv | 114 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a pending-write scoreboard.
// NRD combinational read ports, one synchronous write port, and a busy bit
// per register that marks an in-flight multi-cycle producer. x0 reads as zero
// and can never be written or marked busy.
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int AW     = 5,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*XLEN-1:0]   rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic                  iss_en,
   input  logic [AW-1:0]         iss_addr,
   output logic [(2**AW)-1:0]    busy_vec,
   output logic [AW:0]           pend_cnt,
   output logic                  pend_full
);

   localparam int NREG = 2**AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(NREG - 1);

   // Strobe semantics: wr_en and iss_en are single-cycle qualifiers with no
   // back-pressure; each is sampled on every rising edge and acts exactly once
   // per cycle it is high. A strobe aimed at x0 is dropped.

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_nxt;
   logic [AW:0]     cnt_q;
   logic [AW:0]     cnt_nxt;
   logic            full_q;
   logic            wr_ok;
   logic            iss_ok;
   logic            set_bit;
   logic            clr_bit;

   assign wr_ok  = wr_en  && (wr_addr  != '0);
   assign iss_ok = iss_en && (iss_addr != '0);

   // A 0->1 transition happens only when the issue target was idle. A 1->0
   // transition needs a write to a busy register that is not re-issued in the
   // same cycle (the new producer wins and keeps the bit set).
   assign set_bit = iss_ok && !busy_q[iss_addr];
   assign clr_bit = wr_ok && busy_q[wr_addr] && !(iss_ok && (iss_addr == wr_addr));

   // Next busy vector: write clears, then issue sets so issue has priority.
   always_comb begin
      busy_nxt = busy_q;
      if (wr_ok)
         busy_nxt[wr_addr] = 1'b0;
      if (iss_ok)
         busy_nxt[iss_addr] = 1'b1;
   end

   // Incremental pending counter; tracks popcount(busy_q) edge by edge.
   always_comb begin
      cnt_nxt = cnt_q + {{AW{1'b0}}, set_bit} - {{AW{1'b0}}, clr_bit};
   end

   // Register array storage; x0 is never written so it stays zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Scoreboard state: busy bits, pending count and full flag, all flopped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         busy_q <= busy_nxt;
         cnt_q  <= cnt_nxt;
         full_q <= (cnt_nxt == FULL_CNT);
      end
   end

   assign busy_vec  = busy_q;
   assign pend_cnt  = cnt_q;
   assign pend_full = full_q;

   // Read ports: x0 is zero and never busy; a matching same-cycle write is
   // forwarded (and reported not busy) when bypass is enabled.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rd_addr[i*AW +: AW] == '0) begin
            rd_data[i*XLEN +: XLEN] = '0;
            rd_busy[i]              = 1'b0;
         end else if ((BYPASS != 0) && rst && wr_en &&
                      (wr_addr == rd_addr[i*AW +: AW])) begin
            rd_data[i*XLEN +: XLEN] = wr_data;
            rd_busy[i]              = 1'b0;
         end else begin
            rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
            rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
         end
      end
   end

endmodule
